// File: rtl/uart_echo_sequencer.sv
// Bus-master FSM that runs the UART echo loop (enable, poll rx, read, poll tx, write back)
// over a req/ack MMIO port, reporting echo progress and tx stalls.
module uart_echo_sequencer #(
   parameter logic [31:0] UART_BASE  = 32'h10013000,
   parameter int unsigned POLL_GAP   = 4,
   parameter int unsigned TX_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        req,
   output logic        we,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        ack,
   input  logic [31:0] rdata,
   output logic        busy,
   output logic [15:0] echo_count,
   output logic [7:0]  last_byte,
   output logic        tx_stall
);
   typedef enum logic [2:0] {
      IDLE, EN_WR, RX_POLL, RX_GAP, RX_READ, TX_POLL, TX_GAP, TX_WRITE
   } state_t;

   localparam logic [31:0] A_DATA = UART_BASE;
   localparam logic [31:0] A_STAT = UART_BASE + 32'd4;
   localparam logic [31:0] A_CTRL = UART_BASE + 32'd8;

   state_t      r_state;
   logic        r_req, r_we, r_busy, r_tx_stall;
   logic [31:0] r_addr, r_wdata;
   logic [15:0] r_echo_count, r_stall_cnt;
   logic [7:0]  r_last_byte, r_byte, r_gap;

   logic        w_gap_done;
   logic [15:0] w_stall_inc;
   logic        w_stall_hit;

   // Gap states exit after max(POLL_GAP,1) idle cycles; the exit itself raises the next poll.
   assign w_gap_done  = ({1'b0, r_gap} + 9'd1) >= 9'(POLL_GAP);
   assign w_stall_inc = (r_stall_cnt == 16'hFFFF) ? r_stall_cnt : r_stall_cnt + 16'd1;
   assign w_stall_hit = {16'd0, w_stall_inc} >= TX_TIMEOUT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_busy       <= 1'b0;
         r_tx_stall   <= 1'b0;
         r_echo_count <= '0;
         r_last_byte  <= '0;
         r_stall_cnt  <= '0;
         r_byte       <= '0;
         r_gap        <= '0;
      end else begin
         case (r_state)
            IDLE: if (en) begin
               r_state <= EN_WR;
               r_busy  <= 1'b1;
            end
            EN_WR:
               if (!r_req) begin
                  r_req   <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= A_CTRL;
                  r_wdata <= 32'd1;
               end else if (ack) begin
                  r_req   <= 1'b0;
                  r_state <= RX_POLL;
               end
            RX_POLL:
               if (!r_req) begin
                  r_req  <= 1'b1;
                  r_we   <= 1'b0;
                  r_addr <= A_STAT;
               end else if (ack) begin
                  r_req   <= 1'b0;
                  r_gap   <= '0;
                  r_state <= rdata[2] ? RX_READ : RX_GAP;
               end
            RX_GAP:
               if (!w_gap_done) begin
                  r_gap <= r_gap + 8'd1;
               end else if (!en) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= RX_POLL;
                  r_req   <= 1'b1;
                  r_we    <= 1'b0;
                  r_addr  <= A_STAT;
               end
            RX_READ:
               if (!r_req) begin
                  r_req  <= 1'b1;
                  r_we   <= 1'b0;
                  r_addr <= A_DATA;
               end else if (ack) begin
                  r_req       <= 1'b0;
                  r_byte      <= rdata[7:0];
                  r_stall_cnt <= '0;
                  r_state     <= TX_POLL;
               end
            TX_POLL:
               if (!r_req) begin
                  r_req  <= 1'b1;
                  r_we   <= 1'b0;
                  r_addr <= A_STAT;
               end else if (ack) begin
                  r_req <= 1'b0;
                  if (rdata[1]) begin
                     r_state <= TX_WRITE;
                  end else begin
                     r_stall_cnt <= w_stall_inc;
                     if (w_stall_hit) r_tx_stall <= 1'b1;
                     r_gap   <= '0;
                     r_state <= TX_GAP;
                  end
               end
            // en is deliberately ignored here so a byte already read is always written back.
            TX_GAP:
               if (!w_gap_done) begin
                  r_gap <= r_gap + 8'd1;
               end else begin
                  r_state <= TX_POLL;
                  r_req   <= 1'b1;
                  r_we    <= 1'b0;
                  r_addr  <= A_STAT;
               end
            TX_WRITE:
               if (!r_req) begin
                  r_req   <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= A_DATA;
                  r_wdata <= {24'd0, r_byte};
               end else if (ack) begin
                  r_req        <= 1'b0;
                  r_echo_count <= r_echo_count + 16'd1;
                  r_last_byte  <= r_byte;
                  r_tx_stall   <= 1'b0;
                  r_stall_cnt  <= '0;
                  r_state      <= en ? RX_POLL : IDLE;
                  r_busy       <= en;
               end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign req        = r_req;
   assign we         = r_we;
   assign addr       = r_addr;
   assign wdata      = r_wdata;
   assign busy       = r_busy;
   assign echo_count = r_echo_count;
   assign last_byte  = r_last_byte;
   assign tx_stall   = r_tx_stall;
endmodule

// File: tb/tb_uart_echo_sequencer.sv
// Directed bench for uart_echo_sequencer: a scripted UART slave with programmable ack delay
// logs every bus transaction; each test task checks the log and the status outputs.
module tb_uart_echo_sequencer;
   localparam logic [31:0] BASE   = 32'h10013000;
   localparam logic [31:0] A_DATA = 32'h10013000;
   localparam logic [31:0] A_STAT = 32'h10013004;
   localparam logic [31:0] A_CTRL = 32'h10013008;

   logic        clk, rst_n, en, req, we, ack, busy, tx_stall;
   logic [31:0] addr, wdata, rdata;
   logic [15:0] echo_count;
   logic [7:0]  last_byte;

   int total = 0;
   int bad   = 0;

   uart_echo_sequencer #(.UART_BASE(BASE), .POLL_GAP(4), .TX_TIMEOUT(3)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .busy(busy), .echo_count(echo_count), .last_byte(last_byte),
      .tx_stall(tx_stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scripted slave: status/data response queues, transaction log, stability monitor.
   logic [31:0] sq[$], dq[$], lg_addr[$], lg_wdata[$];
   logic        lg_we[$];
   int          lg_start[$], lg_end[$];
   int          ack_dly = 0;
   int          stab_err = 0;
   int          cyc = 0;
   int          wcnt = 0;
   int          t_start = 0;
   bit          in_txn = 0;
   logic [31:0] c_addr, c_wdata;
   logic        c_we;

   initial begin
      ack = 1'b0;
      rdata = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n || !req) begin
            ack = 1'b0; in_txn = 0; wcnt = 0;
         end else if (ack) begin
            ack = 1'b0; in_txn = 0; wcnt = 0;
         end else begin
            if (!in_txn) begin
               in_txn = 1; c_addr = addr; c_we = we; c_wdata = wdata; t_start = cyc;
            end else if (addr !== c_addr || we !== c_we || (we && wdata !== c_wdata)) begin
               stab_err++;
            end
            if (wcnt < ack_dly) begin
               wcnt++;
            end else begin
               wcnt = 0;
               ack = 1'b1;
               lg_addr.push_back(addr); lg_we.push_back(we); lg_wdata.push_back(wdata);
               lg_start.push_back(t_start); lg_end.push_back(cyc);
               if (!we && addr == A_STAT)      rdata = (sq.size() != 0) ? sq.pop_front() : 32'h0;
               else if (!we && addr == A_DATA) rdata = (dq.size() != 0) ? dq.pop_front() : 32'h0;
               else                            rdata = 32'h0;
            end
         end
      end
   end

   task automatic clr_log();
      lg_addr.delete(); lg_we.delete(); lg_wdata.delete(); lg_start.delete(); lg_end.delete();
      sq.delete(); dq.delete();
      stab_err = 0;
   endtask

   task automatic wait_log(input int n, output bit ok);
      ok = 0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #2;
         if (lg_addr.size() >= n) begin ok = 1; break; end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #2;
         if (busy === 1'b0) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      total++;
      if ({req, we, busy, tx_stall, addr, wdata, echo_count, last_byte} !== '0) begin
         bad++;
         $display("FAIL reset_in: req=%b busy=%b addr=%h wdata=%h cnt=%h last=%h stall=%b want all 0",
                  req, busy, addr, wdata, echo_count, last_byte, tx_stall);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      total++;
      if (req !== 1'b0 || busy !== 1'b0 || echo_count !== 16'h0 || tx_stall !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: req=%b busy=%b cnt=%h stall=%b want 0 0 0000 0",
                  req, busy, echo_count, tx_stall);
      end
   endtask

   // Shared body of the single-echo and slow-slave scenarios.
   task automatic run_echo(input string nm, input logic [31:0] miss, input logic [31:0] txok,
                           input logic [31:0] dat, input logic [15:0] cnt_want);
      logic [31:0] ea [7] = '{A_CTRL, A_STAT, A_STAT, A_STAT, A_DATA, A_STAT, A_DATA};
      logic        ew [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] ed [7] = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h41};
      bit ok;
      clr_log();
      sq = '{miss, miss, 32'h4, txok};
      dq = '{dat};
      en = 1'b1;
      wait_log(7, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL %s_timeout: log=%0d want 7", nm, lg_addr.size()); end
      total++;
      if (echo_count !== cnt_want || last_byte !== 8'h41) begin
         bad++;
         $display("FAIL %s_result: cnt=%h last=%h want %h 41", nm, echo_count, last_byte, cnt_want);
      end
      en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         total++;
         if (i >= lg_addr.size() || lg_addr[i] !== ea[i] || lg_we[i] !== ew[i] ||
             (ew[i] && lg_wdata[i] !== ed[i])) begin
            bad++;
            $display("FAIL %s_txn%0d: addr=%h we=%b wdata=%h want %h %b %h", nm, i,
                     (i < lg_addr.size()) ? lg_addr[i] : 32'hx, (i < lg_we.size()) ? lg_we[i] : 1'bx,
                     (i < lg_wdata.size()) ? lg_wdata[i] : 32'hx, ea[i], ew[i], ed[i]);
         end
      end
      for (int i = 1; i < 3; i++) begin
         total++;
         if (lg_addr.size() < 4 || lg_start[i+1] - lg_end[i] - 1 != 4) begin
            bad++;
            $display("FAIL %s_gap%0d: idle=%0d want 4", nm, i,
                     (lg_addr.size() < 4) ? -1 : lg_start[i+1] - lg_end[i] - 1);
         end
      end
      total++;
      if (stab_err != 0) begin bad++; $display("FAIL %s_stable: changes=%0d want 0", nm, stab_err); end
      wait_idle(ok);
      total++;
      if (!ok || echo_count !== cnt_want) begin
         bad++;
         $display("FAIL %s_idle: busy=%b cnt=%h want 0 %h", nm, busy, echo_count, cnt_want);
      end
   endtask

   task automatic test_single_echo();
      ack_dly = 0;
      run_echo("single", 32'h0, 32'h2, 32'h41, 16'd1);
   endtask

   task automatic test_slow_slave();
      ack_dly = 5;
      run_echo("slow", 32'hFFFF_FFF9, 32'h0000_000B, 32'hABCD_EF41, 16'd2);
      ack_dly = 0;
   endtask

   task automatic test_tx_stall();
      bit ok;
      clr_log();
      sq = '{32'h4, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h2};
      dq = '{32'h5A};
      en = 1'b1;
      wait_log(5, ok);
      total++;
      if (!ok || tx_stall !== 1'b0) begin
         bad++; $display("FAIL stall_after2: ok=%0d stall=%b want 1 0", ok, tx_stall);
      end
      wait_log(6, ok);
      total++;
      if (!ok || tx_stall !== 1'b1) begin
         bad++; $display("FAIL stall_after3: ok=%0d stall=%b want 1 1", ok, tx_stall);
      end
      wait_log(8, ok);
      total++;
      if (!ok || tx_stall !== 1'b0 || last_byte !== 8'h5A || echo_count !== 16'd3) begin
         bad++;
         $display("FAIL stall_clear: stall=%b last=%h cnt=%h want 0 5a 0003", tx_stall, last_byte, echo_count);
      end
      total++;
      if (lg_addr.size() < 8 || lg_addr[7] !== A_DATA || lg_we[7] !== 1'b1 || lg_wdata[7] !== 32'h5A) begin
         bad++; $display("FAIL stall_write: log=%0d want write %h=0000005a", lg_addr.size(), A_DATA);
      end
      en = 1'b0;
      wait_idle(ok);
   endtask

   task automatic test_en_drop();
      bit ok;
      clr_log();
      sq = '{32'h4, 32'h0, 32'h2};
      dq = '{32'h77};
      en = 1'b1;
      wait_log(4, ok);
      en = 1'b0;
      wait_log(6, ok);
      total++;
      if (!ok || busy !== 1'b0 || echo_count !== 16'd4 || last_byte !== 8'h77) begin
         bad++;
         $display("FAIL drop_write: ok=%0d busy=%b cnt=%h last=%h want 1 0 0004 77", ok, busy, echo_count, last_byte);
      end
      total++;
      if (lg_addr.size() < 6 || lg_addr[5] !== A_DATA || lg_we[5] !== 1'b1 || lg_wdata[5] !== 32'h77) begin
         bad++; $display("FAIL drop_txn: log=%0d want write %h=00000077 at 5", lg_addr.size(), A_DATA);
      end
      repeat (10) @(posedge clk);
      #2;
      total++;
      if (lg_addr.size() != 6 || req !== 1'b0) begin
         bad++; $display("FAIL drop_quiet: log=%0d req=%b want 6 0", lg_addr.size(), req);
      end
      clr_log();
      en = 1'b1;
      wait_log(1, ok);
      total++;
      if (!ok || lg_addr[0] !== A_CTRL || lg_we[0] !== 1'b1 || lg_wdata[0] !== 32'h1) begin
         bad++; $display("FAIL drop_reenable: ok=%0d first txn not write %h=1", ok, A_CTRL);
      end
      en = 1'b0;
      wait_idle(ok);
   endtask

   task automatic test_wrap_reset();
      bit ok;
      clr_log();
      @(negedge clk);
      force dut.r_echo_count = 16'hFFFF;
      @(negedge clk);
      release dut.r_echo_count;
      sq = '{32'h4, 32'h2};
      dq = '{32'h99};
      en = 1'b1;
      wait_log(5, ok);
      total++;
      if (!ok || echo_count !== 16'h0 || last_byte !== 8'h99) begin
         bad++; $display("FAIL wrap: ok=%0d cnt=%h last=%h want 1 0000 99", ok, echo_count, last_byte);
      end
      ack_dly = 5;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #2;
         if (req === 1'b1) begin ok = 1; break; end
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (!ok || {req, we, busy, tx_stall, addr, wdata, echo_count, last_byte} !== '0) begin
         bad++;
         $display("FAIL async_reset: ok=%0d req=%b busy=%b addr=%h cnt=%h last=%h want 1 and all 0",
                  ok, req, busy, addr, echo_count, last_byte);
      end
      en = 1'b0;
      ack_dly = 0;
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_single_echo();
      test_slow_slave();
      test_tx_stall();
      test_en_drop();
      test_wrap_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_echo_sequencer.md
Name: uart_echo_sequencer

Overview:
Hardware bus-master FSM that runs the UART echo loop without the CPU. It enables the UART, polls status for rx_valid, reads the received byte, polls for tx_ready and writes the byte back. It drives the UART's 32-bit MMIO register port (data +0x0, status +0x4 with bit1 = tx_ready and bit2 = rx_valid, control +0x8 with bit0 = enable) through a simple req/ack master interface. It also reports progress and stall status to the SoC.

Parameters:
UART_BASE, 32'h10013000, byte base address of the UART register block
POLL_GAP, 4, idle cycles inserted between consecutive unsuccessful status polls (legal range 0..255)
TX_TIMEOUT, 16, consecutive failed tx_ready polls before tx_stall asserts (legal range 1..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run request; level-sensitive
req  out  1  bus request; held until ack
we  out  1  1 = write, 0 = read; valid while req
addr  out  32  byte address; valid while req
wdata  out  32  write data; valid while req and we
ack  in  1  transaction completes on the rising edge where req and ack are both 1
rdata  in  32  read data; valid in the ack cycle of a read
busy  out  1  FSM not in IDLE
echo_count  out  16  bytes echoed since reset; wraps from 0xFFFF to 0
last_byte  out  8  most recently echoed byte
tx_stall  out  1  tx_ready has been absent for at least TX_TIMEOUT consecutive polls

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state = IDLE; req, we, busy, tx_stall = 0; addr, wdata = 0; echo_count = 0; last_byte = 0; internal gap counter, stall counter and byte register = 0.
- Reset while a transaction is in flight: req drops immediately. No completion is assumed.
- Output registering: all outputs are registered.
- Bus handshake:
  - req/we/addr/wdata stay stable from assertion until the ack edge.
  - req is low in the cycle after the ack edge, giving at least one idle cycle between transactions.
  - ack while req = 0 is ignored.
  - No transaction is ever abandoned, whatever en does.
- States:
  - IDLE: if en = 1, go to EN_WR.
  - EN_WR: write addr = BASE+8, wdata = 1. On ack, go to RX_POLL.
  - RX_POLL: read BASE+4. On ack: if rdata[2] = 1, go to RX_READ; otherwise go to RX_GAP.
  - RX_GAP: wait POLL_GAP cycles (with 0, the next poll request follows the mandatory idle cycle). Then go to IDLE if en = 0, otherwise to RX_POLL.
  - RX_READ: read BASE+0. On ack, latch rdata[7:0] into the byte register, clear the stall counter, go to TX_POLL.
  - TX_POLL: read BASE+4. On ack:
    - if rdata[1] = 1, go to TX_WRITE;
    - otherwise increment the stall counter (saturating at 0xFFFF), set tx_stall = 1 if the counter is at least TX_TIMEOUT, and go to TX_GAP.
  - TX_GAP: wait POLL_GAP cycles, then go to TX_POLL. en is ignored here; a received byte is never dropped.
  - TX_WRITE: write BASE+0, wdata = {24'b0, byte}. On ack:
    - echo_count increments by 1 (mod 2^16);
    - last_byte takes the byte value;
    - tx_stall and the stall counter clear;
    - next state is IDLE if en = 0, otherwise RX_POLL.
- en is sampled only at the RX_GAP exit, the TX_WRITE exit and in IDLE. Every IDLE→EN_WR entry rewrites the enable register.
- busy = (state != IDLE), registered with the state.
- Read data bits other than those named are ignored.
- Status bits are evaluated only in the ack cycle of the read.

Test Plan:
- Reset/idle: hold rst_n low, then release with en = 0 for 20 cycles → req = 0, busy = 0, echo_count = 0, tx_stall = 0.
- Single echo (zero-wait slave, POLL_GAP = 4):
  - stimulus: raise en; status reads 0x0 twice, then 0x4; data read returns 0x41; next status read 0x2;
  - required bus sequence: write 0x10013008 = 1, then reads 0x10013004 (×3) with 4-cycle gaps after the misses, then read 0x10013000, then read 0x10013004, then write 0x10013000 = 0x41;
  - after the write: echo_count = 1, last_byte = 0x41.
- Slow slave: ack delayed 5 cycles on every transaction → addr/we/wdata stable throughout, exactly one completion per ack, and the same echo result as the single-echo case.
- TX stall, TX_TIMEOUT = 3: return tx_ready = 0 on 3 polls → tx_stall = 1 after the third poll ack. Then return tx_ready = 1 → byte written, tx_stall = 0.
- en drop mid-byte: deassert en during TX_GAP → FSM still writes the pending byte, then goes to IDLE (busy = 0). Re-raise en → a new write to 0x10013008 occurs.
- Wrap and async reset:
  - preload 0xFFFF echoes (or force the count) and perform one more echo → echo_count = 0;
  - assert rst_n low while req = 1 → req = 0 immediately, and all outputs return to their reset values.
